// File: rtl/bus_arbiter8.sv
// bus_arbiter8: round-robin arbiter and sequencer for the shared 8-bit bus.
// It grants one requester at a time and drives the 8:1 mux select S to the
// owner's index. A hold timer forces release when others are waiting, and a
// one-cycle GAP state separates successive owners.
module bus_arbiter8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] S,
  output logic [7:0] grant,
  output logic       busy,
  output logic       preempt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
  localparam bit         HOLD_EN  = (MAX_HOLD != 0);

  state_t     state, state_nxt;
  logic [2:0] last, last_nxt;
  logic [2:0] s_nxt;
  logic [7:0] grant_nxt;
  logic       busy_nxt, preempt_nxt;
  logic [7:0] cnt, cnt_nxt;

  logic [2:0] win, idx;
  logic       found;
  logic       rel_drop, rel_force, release_now;

  // Rotating priority search: first set request at or after last+1, wrapping.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    win   = last;
    idx   = last;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = last + 3'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Release causes while owning. The timer compares with >= so that once the
  // limit has passed with nobody waiting, the owner is preempted as soon as
  // another request shows up.
  always_comb begin
    rel_drop    = ~req[S];
    rel_force   = HOLD_EN && (cnt >= HOLD_LIM) && ((req & ~grant) != 8'd0);
    release_now = done || rel_drop || rel_force;
  end

  // Next-state and next-output logic; by default everything holds.
  always_comb begin
    state_nxt   = state;
    last_nxt    = last;
    s_nxt       = S;
    grant_nxt   = grant;
    busy_nxt    = busy;
    preempt_nxt = 1'b0;
    cnt_nxt     = cnt;
    case (state)
      IDLE: begin
        if (req != 8'd0) begin
          state_nxt = OWN;
          grant_nxt = 8'd1 << win;
          s_nxt     = win;
          busy_nxt  = 1'b1;
          cnt_nxt   = 8'd1;
        end
      end
      OWN: begin
        if (release_now) begin
          state_nxt   = GAP;
          grant_nxt   = 8'd0;
          busy_nxt    = 1'b0;
          last_nxt    = S;
          // Forced release is reported only when it is the sole cause.
          preempt_nxt = rel_force && !done && !rel_drop;
        end else if (cnt != 8'hFF) begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      GAP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 8'd0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled before the edge.
    if (rst) begin
      state   <= IDLE;
      last    <= 3'd7;
      S       <= 3'd0;
      grant   <= 8'd0;
      busy    <= 1'b0;
      preempt <= 1'b0;
      cnt     <= 8'd0;
    end else begin
      state   <= state_nxt;
      last    <= last_nxt;
      S       <= s_nxt;
      grant   <= grant_nxt;
      busy    <= busy_nxt;
      preempt <= preempt_nxt;
      cnt     <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_bus_arbiter8.sv
// Directed self-checking bench for bus_arbiter8 with a hold limit of 4.
module tb_bus_arbiter8;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [2:0] S;
  logic [7:0] grant;
  logic       busy;
  logic       preempt;

  int checks   = 0;
  int failures = 0;

  bus_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .S       (S),
    .grant   (grant),
    .busy    (busy),
    .preempt (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle before sampling outputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [7:0] g, input logic [2:0] s,
                            input logic b, input logic p);
    check({tag, ".grant"},   32'(grant),   32'(g));
    check({tag, ".S"},       32'(S),       32'(s));
    check({tag, ".busy"},    32'(busy),    32'(b));
    check({tag, ".preempt"}, 32'(preempt), 32'(p));
  endtask

  initial begin
    rst  = 1'b1;
    req  = 8'h00;
    done = 1'b0;

    // Reset and idle.
    tick();
    tick();
    expect_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_out("idle", 8'h00, 3'd0, 1'b0, 1'b0);
    end

    // Single requester 5, done on the 4th owned cycle, then re-grant.
    req = 8'h20;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_out("single_own", 8'h20, 3'd5, 1'b1, 1'b0);
    end
    done = 1'b1;
    tick();
    expect_out("single_gap", 8'h00, 3'd5, 1'b0, 1'b0);
    done = 1'b0;
    tick();
    expect_out("single_idle", 8'h00, 3'd5, 1'b0, 1'b0);
    tick();
    expect_out("single_regrant", 8'h20, 3'd5, 1'b1, 1'b0);
    req = 8'h00;
    tick();
    expect_out("single_drop_gap", 8'h00, 3'd5, 1'b0, 1'b0);
    tick();

    // Round-robin fairness from reset: 0..7 then 0 again.
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    req  = 8'hFF;
    done = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      expect_out("rr_own", 8'(1 << (k % 8)), 3'(k % 8), 1'b1, 1'b0);
      tick();
      expect_out("rr_gap", 8'h00, 3'(k % 8), 1'b0, 1'b0);
      tick();
      expect_out("rr_idle", 8'h00, 3'(k % 8), 1'b0, 1'b0);
    end
    req  = 8'h00;
    done = 1'b0;
    tick();

    // Preemption between requesters 0 and 1.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 8'h03;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_out("pre_own0", 8'h01, 3'd0, 1'b1, 1'b0);
    end
    tick();
    expect_out("pre_gap0", 8'h00, 3'd0, 1'b0, 1'b1);
    tick();
    expect_out("pre_idle0", 8'h00, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_out("pre_own1", 8'h02, 3'd1, 1'b1, 1'b0);
    end
    tick();
    expect_out("pre_gap1", 8'h00, 3'd1, 1'b0, 1'b1);
    tick();
    tick();
    expect_out("pre_own0_again", 8'h01, 3'd0, 1'b1, 1'b0);
    req = 8'h00;
    tick();
    expect_out("pre_drop_gap", 8'h00, 3'd0, 1'b0, 1'b0);
    tick();

    // Sole requester keeps the bus past the limit; preempted once 0 appears.
    req = 8'h04;
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_out("alone_own", 8'h04, 3'd2, 1'b1, 1'b0);
    end
    req = 8'h05;
    tick();
    expect_out("alone_preempt", 8'h00, 3'd2, 1'b0, 1'b1);
    tick();
    expect_out("alone_idle", 8'h00, 3'd2, 1'b0, 1'b0);
    tick();
    expect_out("alone_next_own", 8'h01, 3'd0, 1'b1, 1'b0);

    // Reset in the middle of owner 6's window.
    req = 8'h40;
    tick();
    expect_out("mid_gap", 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    tick();
    expect_out("mid_own6", 8'h40, 3'd6, 1'b1, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    expect_out("mid_reset", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    req = 8'h41;
    tick();
    expect_out("post_reset_own0", 8'h01, 3'd0, 1'b1, 1'b0);

    // done coinciding with an expired timer and a waiter: no preempt pulse.
    tick();
    tick();
    tick();
    expect_out("coinc_own0", 8'h01, 3'd0, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    expect_out("coinc_gap", 8'h00, 3'd0, 1'b0, 1'b0);
    done = 1'b0;
    tick();
    tick();
    expect_out("coinc_next_own6", 8'h40, 3'd6, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
